stream_write_bank: RTL and testbench

//  Multi-lane byte-bank buffer. Parallel row writes go in with per-lane masks.
//  A handshaked engine streams rows back out one lane per beat, auto-incrementing the row address.

---
 rtl/wb_pkg.sv | 19 +
 rtl/sdp_ram.sv | 36 +++
 rtl/stream_write_bank.sv | 176 +++++++++++++++++
 tb/tb_stream_write_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the stream_write_bank row buffer.
// Optional parity storage is selected in the top by STREAM_WRITE_BANK_PARITY_EN.
package wb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } wb_state_t;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle returns the old word.
module sdp_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/stream_write_bank.sv
// Multi-lane byte-bank buffer: masked parallel row writes, handshaked lane-per-beat readout.
// Define STREAM_WRITE_BANK_PARITY_EN to store a parity bit per lane and expose out_par_err.
module stream_write_bank
    import wb_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [addr_w(DEPTH)-1:0]       wr_addr,
    input  logic [LANES-1:0]               wr_mask,
    input  logic [LANES*DATA_W-1:0]        wr_data,
    input  logic                           rd_start,
    input  logic [addr_w(DEPTH)-1:0]       rd_base,
    input  logic [addr_w(DEPTH):0]         rd_rows,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
`ifdef STREAM_WRITE_BANK_PARITY_EN
    ,
    output logic                           out_par_err
`endif
);

    localparam int AW = addr_w(DEPTH);
    localparam int LW = $clog2(LANES);
`ifdef STREAM_WRITE_BANK_PARITY_EN
    localparam int RW = DATA_W + 1;
`else
    localparam int RW = DATA_W;
`endif
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

    function automatic logic par_of(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    wb_state_t            state_q;
    logic [AW-1:0]        row_ptr_q;
    logic [AW:0]          rows_left_q;
    logic [LW-1:0]        lane_q;
    logic [LANES*RW-1:0]  row_q;
    logic                 out_valid_q;
    logic [DATA_W-1:0]    out_data_q;
    logic                 out_last_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 par_err_q;

    logic [LANES*RW-1:0]  ram_rdata_s;
    logic [LW-1:0]        lane_nxt_s;
    int                   nxt_base_s;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [RW-1:0] wword_s;
`ifdef STREAM_WRITE_BANK_PARITY_EN
        assign wword_s = {par_of(wr_data[g*DATA_W +: DATA_W]), wr_data[g*DATA_W +: DATA_W]};
`else
        assign wword_s = wr_data[g*DATA_W +: DATA_W];
`endif
        sdp_ram #(.W(RW), .DEPTH(DEPTH), .AW(AW)) u_ram (
            .clk       (clk),
            .wr_en_i   (wr_en & wr_mask[g]),
            .wr_addr_i (wr_addr),
            .wr_data_i (wword_s),
            .rd_en_i   (state_q == FETCH),
            .rd_addr_i (row_ptr_q),
            .rd_data_o (ram_rdata_s[g*RW +: RW])
        );
    end

    assign lane_nxt_s = lane_q + 1'b1;
    assign nxt_base_s = int'(lane_nxt_s) * RW;

    // Transaction FSM; every output is registered here so it is stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_ptr_q   <= '0;
            rows_left_q <= '0;
            lane_q      <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (rd_start) begin
                        row_ptr_q   <= rd_base;
                        rows_left_q <= rd_rows;
                        if (rd_rows == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= FETCH;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                FETCH: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    row_q       <= ram_rdata_s;
                    lane_q      <= '0;
                    out_valid_q <= 1'b1;
                    out_data_q  <= ram_rdata_s[DATA_W-1:0];
                    out_last_q  <= 1'b0;
                    par_err_q   <= ^ram_rdata_s[RW-1:0];
                    state_q     <= STREAM;
                end
                STREAM: begin
                    if (out_ready) begin
                        if (lane_q != LANE_LAST) begin
                            lane_q     <= lane_nxt_s;
                            out_data_q <= row_q[nxt_base_s +: DATA_W];
                            par_err_q  <= ^row_q[nxt_base_s +: RW];
                            out_last_q <= (lane_nxt_s == LANE_LAST) && (rows_left_q == (AW+1)'(1));
                        end else begin
                            rows_left_q <= rows_left_q - 1'b1;
                            row_ptr_q   <= row_ptr_q + 1'b1;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_last_q  <= 1'b0;
                            par_err_q   <= 1'b0;
                            if (rows_left_q > (AW+1)'(1)) begin
                                state_q <= FETCH;
                            end else begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end else begin
                        lane_q <= lane_q;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef STREAM_WRITE_BANK_PARITY_EN
    assign out_par_err = par_err_q & out_valid_q;
`endif

endmodule

// File: tb/tb_stream_write_bank.sv
// Self-checking bench for stream_write_bank: directed steps with random data/ready against a row-array model.
module tb_stream_write_bank;

    localparam int LANES  = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 512;
    localparam int AW     = 9;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [LANES-1:0]        wr_mask;
    logic [LANES*DATA_W-1:0] wr_data;
    logic                    rd_start;
    logic [AW-1:0]           rd_base;
    logic [AW:0]             rd_rows;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic                    busy;
    logic                    done;
`ifdef STREAM_WRITE_BANK_PARITY_EN
    logic                    out_par_err;
`endif

    int checks   = 0;
    int failures = 0;
    int par_lane = -1;
    logic [7:0] model [DEPTH][LANES];

    stream_write_bank #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_mask   (wr_mask),
        .wr_data   (wr_data),
        .rd_start  (rd_start),
        .rd_base   (rd_base),
        .rd_rows   (rd_rows),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef STREAM_WRITE_BANK_PARITY_EN
        ,
        .out_par_err (out_par_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int addr, input logic [7:0] mask, input logic [63:0] data);
        for (int l = 0; l < LANES; l++) begin
            if (mask[l]) model[addr][l] = data[l*8 +: 8];
        end
    endtask

    task automatic do_write(input int addr, input logic [7:0] mask, input logic [63:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_mask = mask; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        model_write(addr, mask, data);
    endtask

    // Run one transaction; optionally write a full row during cycle wr_cycle and poke rd_start while busy.
    task automatic run_stream(input int base, input int rows, input bit rand_ready,
                              input int wr_cycle, input int wr_row, input logic [63:0] wr_d,
                              input bit try_restart);
        logic [7:0] expq[$];
        int total, k, exp_c;
        bit prev_stall, got_done;
        logic [7:0] prev_data;
        logic prev_last;
        for (int r = 0; r < rows; r++)
            for (int l = 0; l < LANES; l++)
                expq.push_back(model[(base + r) % DEPTH][l]);
        total = expq.size(); k = 0; prev_stall = 0; got_done = 0;
        prev_data = '0; prev_last = 1'b0;
        @(negedge clk);
        rd_start = 1'b1; rd_base = AW'(base); rd_rows = (AW+1)'(rows); out_ready = 1'b0;
        for (int c = 1; c <= 2000 && !got_done; c++) begin
            @(negedge clk);
            rd_start = try_restart && (c == 5);
            rd_base  = AW'(base + 7);
            rd_rows  = (AW+1)'(3);
            if (c == wr_cycle) begin
                wr_en = 1'b1; wr_addr = AW'(wr_row); wr_mask = 8'hFF; wr_data = wr_d;
            end else begin
                wr_en = 1'b0;
            end
            if (c == 1 && rows > 0) chk("busy_after_start", busy, 1);
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                chk("extra_beat", k < total, 1);
                if (k < total) begin
                    chk("beat_data", out_data, expq[k]);
                    chk("beat_last", out_last, k == total - 1);
`ifdef STREAM_WRITE_BANK_PARITY_EN
                    chk("beat_par_err", out_par_err, (k % LANES) == par_lane);
`endif
                    if (!rand_ready) chk("beat_cycle", c, 3 + k + 2 * (k / LANES));
                end
                k++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) begin
                got_done = 1;
                chk("beats_at_done", k, total);
                exp_c = (total == 0) ? 1 : 3 + (total - 1) + 2 * ((total - 1) / LANES) + 1;
                if (!rand_ready) chk("done_cycle", c, exp_c);
                chk("busy_at_done", busy, 0);
            end
        end
        chk("done_seen", got_done, 1);
        wr_en = 1'b0; rd_start = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_done_busy", busy, 0);
        chk("idle_after_done_pulse", done, 0);
        if (wr_cycle > 0) model_write(wr_row, 8'hFF, wr_d);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        rd_start = 1'b0; rd_base = '0; rd_rows = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_valid", out_valid, 0);
            chk("idle_done", done, 0);
        end

        do_write(5, 8'hFF, 64'h0706050403020100);
        run_stream(5, 1, 1'b0, 0, 0, 64'h0, 1'b0);

        do_write(511, 8'hFF, {$urandom, $urandom});
        do_write(0, 8'hFF, {$urandom, $urandom});
        run_stream(511, 2, 1'b0, 0, 0, 64'h0, 1'b0);

        for (int r = 100; r < 104; r++) do_write(r, 8'hFF, {$urandom, $urandom});
        run_stream(100, 4, 1'b1, 0, 0, 64'h0, 1'b1);

        do_write(3, 8'hFF, {8{8'h55}});
        do_write(3, 8'h0F, {8{8'hAA}});
        chk("mask_model_lo", model[3][0], 8'hAA);
        chk("mask_model_hi", model[3][7], 8'h55);
        run_stream(3, 1, 1'b0, 5, 3, {8{8'h11}}, 1'b0);
        run_stream(3, 1, 1'b0, 1, 3, {8{8'h22}}, 1'b0);
        run_stream(3, 1, 1'b0, 0, 0, 64'h0, 1'b0);

        do_write(3, 8'h00, {8{8'hFF}});
        run_stream(3, 1, 1'b1, 0, 0, 64'h0, 1'b0);

        run_stream(9, 0, 1'b0, 0, 0, 64'h0, 1'b0);

        @(negedge clk);
        rd_start = 1'b1; rd_base = AW'(5); rd_rows = (AW+1)'(1); out_ready = 1'b0;
        @(negedge clk);
        rd_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_last", out_last, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", out_data, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_abort_done", done, 0);
            chk("post_abort_busy", busy, 0);
        end

`ifdef STREAM_WRITE_BANK_PARITY_EN
        do_write(7, 8'hFF, {$urandom, $urandom});
        u_dut.g_lane[2].u_ram.mem_q[7][DATA_W] = ~u_dut.g_lane[2].u_ram.mem_q[7][DATA_W];
        par_lane = 2;
        run_stream(7, 1, 1'b0, 0, 0, 64'h0, 1'b0);
        par_lane = -1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
